// File: rtl/bound_flasher_pkg.sv
// bound_flasher_pkg: shared state encoding and thermometer helper for the bound flasher.
package bound_flasher_pkg;
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  function automatic logic [63:0] therm(input int unsigned n);
    return n >= 64 ? '1 : (64'd1 << n) - 64'd1;
  endfunction
endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: prescaler producing a one-clk tick every STEP_DIV enabled clocks.
module step_tick_gen #(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);
  localparam int DW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(STEP_DIV - 1);
  logic [DW-1:0] cnt;
  assign tick = enable && cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + DW'(1);
  end
endmodule

// File: rtl/bound_flasher_seq.sv
// bound_flasher_seq: table-driven UP/DOWN thermometer sweeps with flick start and kickback.
module bound_flasher_seq
  import bound_flasher_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CW = $clog2(WIDTH + 1),
  parameter int NUM_PHASES = 6,
  parameter logic [NUM_PHASES*CW-1:0] BOUNDS = {5'd0, 5'd6, 5'd0, 5'd11, 5'd5, 5'd16},
  parameter logic [WIDTH:0] CHECKPOINTS = 17'h00021,
  parameter int STEP_DIV = 1,
  parameter int PW = NUM_PHASES > 1 ? $clog2(NUM_PHASES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic flick,
  input  logic enable,
  input  logic repeat_mode,
  output logic [WIDTH-1:0] led,
  output logic [PW-1:0] phase,
  output logic busy,
  output logic done
);
  localparam logic [PW-1:0] LAST_PH = PW'(NUM_PHASES - 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, raw_b, bnd;
  logic [PW-1:0] phase_n;
  logic tick, flick_req, eff, fin;
  step_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .tick(tick)
  );
  assign eff = flick | flick_req;
  assign busy = state != IDLE;
  assign raw_b = BOUNDS[int'(phase)*CW +: CW];
  assign bnd = raw_b > MAX_CNT ? MAX_CNT : raw_b;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    phase_n = phase;
    fin = 1'b0;
    if (tick) begin
      case (state)
        IDLE: if (eff) begin
          state_n = UP;
          phase_n = '0;
          cnt_n = '0;
        end
        UP: if (cnt < bnd) cnt_n = cnt + CW'(1);
        else if (phase != LAST_PH) begin
          state_n = DOWN;
          phase_n = phase + PW'(1);
          cnt_n = cnt == '0 ? cnt : cnt - CW'(1);
        end else fin = 1'b1;
        DOWN: if (eff && phase != LAST_PH && CHECKPOINTS[cnt]) begin
          state_n = UP;
          phase_n = phase - PW'(1);
        end else if (cnt > bnd) cnt_n = cnt - CW'(1);
        else if (phase != LAST_PH) begin
          state_n = UP;
          phase_n = phase + PW'(1);
          cnt_n = cnt == MAX_CNT ? cnt : cnt + CW'(1);
        end else fin = 1'b1;
        default: state_n = IDLE;
      endcase
      if (fin) begin
        state_n = repeat_mode ? UP : IDLE;
        phase_n = '0;
        cnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      phase <= '0;
      led <= '0;
      done <= 1'b0;
      flick_req <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      phase <= phase_n;
      led <= WIDTH'(therm(32'(cnt_n)));
      done <= fin;
      flick_req <= tick ? 1'b0 : flick_req | flick;
    end
  end
endmodule
